// File: rtl/div_ctrl.sv
// Iterative 32-bit radix-2 restoring divider with sequencing FSM for DIV/DIVU.
// Holds the pipeline via stall_o and returns {remainder, quotient} for HI/LO.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_result;

  logic        w_go;
  logic        w_abort;
  logic        w_div_zero;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_shift;
  logic [31:0] w_diff;
  logic        w_qbit;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign w_go       = start_i & ~annul_i;
  assign w_abort    = annul_i | ~start_i;
  assign w_div_zero = (opdata2_i == 32'd0);

  assign w_abs1 = (signed_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

  // The remainder is always below the divisor, so the trial difference fits in
  // 32 bits whenever the shifted value is not smaller than the divisor.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_qbit     = (w_shift >= {1'b0, r_dvs});
  assign w_diff     = w_shift[31:0] - r_dvs;
  assign w_rem_next = w_qbit ? w_diff : w_shift[31:0];
  assign w_quo_next = {r_quo[30:0], w_qbit};

  assign w_q_fix = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_r_fix = r_neg_r ? -w_rem_next : w_rem_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_next = w_div_zero ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: w_state_next = w_abort ? S_IDLE : S_END;
      S_ON: begin
        if (w_abort) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == 5'd31) begin
          w_state_next = S_END;
        end
      end
      S_END: begin
        if (w_abort) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 5'd0;
      r_quo    <= 32'd0;
      r_rem    <= 32'd0;
      r_dvs    <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go && !w_div_zero) begin
            r_cnt   <= 5'd0;
            r_quo   <= w_abs1;
            r_rem   <= 32'd0;
            r_dvs   <= w_abs2;
            r_neg_q <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
            r_neg_r <= signed_i & opdata1_i[31];
          end
        end
        S_BYZERO: begin
          if (!w_abort) begin
            r_result <= 64'd0;
          end
        end
        S_ON: begin
          if (!w_abort) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_result <= {w_r_fix, w_q_fix};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = (r_state == S_END);
  // Gated by rst so a request held during reset never asserts the stall.
  assign stall_o  = rst & (((r_state == S_IDLE) & w_go) | (r_state == S_ON) | (r_state == S_BYZERO));

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, sign rules, divide-by-zero, abort, handshake, reset.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
  } vec_t;

  div_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stall_o   (stall_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 100000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_i = 1'b1;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    repeat (2) @(negedge clk);
    n_checks++;
    if (result_o !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h required %h", result_o, 64'd0); end
    n_checks++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", ready_o); end
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", stall_o); end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got ready=%b stall=%b required 0 0", ready_o, stall_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_unsigned();
    logic exp_stall;
    logic exp_ready;
    tick();
    signed_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);
      exp_stall = (k <= 32);
      exp_ready = (k == 33);
      n_checks++;
      if (stall_o !== exp_stall) begin n_fail++; $display("FAIL unsigned_stall N+%0d: got %b required %b", k, stall_o, exp_stall); end
      n_checks++;
      if (ready_o !== exp_ready) begin n_fail++; $display("FAIL unsigned_ready N+%0d: got %b required %b", k, ready_o, exp_ready); end
      // Operands change after sampling and must be ignored.
      if (k == 1) begin opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'd3; end
      if (k < 33) tick();
    end
    n_checks++;
    if (result_o !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL unsigned_result: got %h required %h", result_o, 64'h00000002_0000000E); end
    $display("test_unsigned 100/7 result=%h", result_o);
  endtask

  task automatic test_handshake();
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
        n_fail++; $display("FAIL handshake_hold %0d: got ready=%b result=%h required 1 %h", i, ready_o, result_o, 64'h00000002_0000000E);
      end
    end
    tick();
    start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL handshake_drop_cycle: got ready=%b required 1", ready_o); end
    @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL handshake_idle: got ready=%b stall=%b required 0 0", ready_o, stall_o);
    end
    $display("test_handshake done");
  endtask

  task automatic test_signed();
    vec_t vecs[6];
    int lat;
    vecs[0] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD};
    vecs[1] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 64'h00000000_FFFFFFFF};
    vecs[4] = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 64'h00000001_7FFFFFFC};
    vecs[5] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFFFFFE_0000000E};
    for (int v = 0; v < 6; v++) begin
      tick();
      signed_i = vecs[v].sgn;
      opdata1_i = vecs[v].a;
      opdata2_i = vecs[v].b;
      start_i = 1'b1;
      lat = 0;
      @(negedge clk);
      while (ready_o !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      n_checks++;
      if (lat != 33) begin n_fail++; $display("FAIL div_latency vec%0d: got %0d required 33", v, lat); end
      n_checks++;
      if (result_o !== vecs[v].r) begin n_fail++; $display("FAIL div_result vec%0d: got %h required %h", v, result_o, vecs[v].r); end
      $display("test_signed vec%0d s=%b %h/%h result=%h", v, vecs[v].sgn, vecs[v].a, vecs[v].b, result_o);
      tick();
      start_i = 1'b0;
    end
  endtask

  task automatic test_byzero();
    logic exp_stall;
    logic exp_ready;
    tick();
    signed_i = 1'b0;
    opdata1_i = 32'd5;
    opdata2_i = 32'd0;
    start_i = 1'b1;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      exp_stall = (k <= 1);
      exp_ready = (k == 2);
      n_checks++;
      if (stall_o !== exp_stall) begin n_fail++; $display("FAIL byzero_stall N+%0d: got %b required %b", k, stall_o, exp_stall); end
      n_checks++;
      if (ready_o !== exp_ready) begin n_fail++; $display("FAIL byzero_ready N+%0d: got %b required %b", k, ready_o, exp_ready); end
      if (k < 2) tick();
    end
    n_checks++;
    if (result_o !== 64'd0) begin n_fail++; $display("FAIL byzero_result: got %h required %h", result_o, 64'd0); end
    $display("test_byzero 5/0 result=%h", result_o);
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_abort();
    int lat;
    tick();
    signed_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (stall_o !== 1'b1 || ready_o !== 1'b0) begin
        n_fail++; $display("FAIL abort_run N+%0d: got stall=%b ready=%b required 1 0", k, stall_o, ready_o);
      end
      tick();
    end
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 1'b0 || ready_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got stall=%b ready=%b required 0 0", stall_o, ready_o);
    end
    n_checks++;
    if (result_o !== 64'd0) begin n_fail++; $display("FAIL abort_result_kept: got %h required %h", result_o, 64'd0); end
    tick();
    start_i = 1'b1;
    lat = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 33) begin n_fail++; $display("FAIL abort_restart_latency: got %0d required 33", lat); end
    n_checks++;
    if (result_o !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL abort_restart_result: got %h required %h", result_o, 64'h00000002_0000000E); end
    $display("test_abort restart result=%h", result_o);
    tick();
    start_i = 1'b0;
    tick();
    start_i = 1'b1;
    annul_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL annul_priority_stall: got %b required 0", stall_o); end
    tick();
    @(negedge clk);
    n_checks++;
    if (stall_o !== 1'b0 || ready_o !== 1'b0) begin
      n_fail++; $display("FAIL annul_priority_idle: got stall=%b ready=%b required 0 0", stall_o, ready_o);
    end
    $display("test_annul_priority done");
    start_i = 1'b0;
    annul_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    tick();
    signed_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (20) tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (result_o !== 64'd0 || ready_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got result=%h ready=%b stall=%b required 0 0 0", result_o, ready_o, stall_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    signed_i = 1'b1;
    opdata1_i = 32'hFFFF_FFF9;
    opdata2_i = 32'h0000_0002;
    start_i = 1'b1;
    lat = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 33) begin n_fail++; $display("FAIL reset_mid_latency: got %0d required 33", lat); end
    n_checks++;
    if (result_o !== 64'hFFFFFFFF_FFFFFFFD) begin n_fail++; $display("FAIL reset_mid_result: got %h required %h", result_o, 64'hFFFFFFFF_FFFFFFFD); end
    $display("test_reset_mid new divide result=%h", result_o);
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_handshake();
    test_signed();
    test_byzero();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

- Iterative 32-bit divide unit and its sequencing controller, sitting beside the execute stage.
- Takes DIV/DIVU operands and runs a 32-step radix-2 restoring division under a small state machine.
- Holds the pipeline via `stall_o` while the division runs.
- Returns the `{remainder, quotient}` pair for the HI/LO write.

## Interface
Parameters:
- none; data width fixed at 32 (`RegBus`), result 64.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start_i` in 1: divide request; held high by execute stage until `ready_o` seen.
- `signed_i` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i` in 32: dividend; sampled only on IDLE→ON or IDLE→BYZERO transition.
- `opdata2_i` in 32: divisor; sampled only on IDLE→ON or IDLE→BYZERO transition.
- `annul_i` in 1: cancel (flush/exception); aborts any in-flight divide.
- `result_o` out 64: `{remainder[63:32], quotient[31:0]}`; valid while `ready_o`=1.
- `ready_o` out 1: result valid.
- `stall_o` out 1: pipeline hold request.

## Operation
States: IDLE, BYZERO, ON, END (2-bit register); 5-bit step counter `cnt`.

IDLE:
- `start_i`=1, `annul_i`=0, divisor≠0 → ON.
  - Latch |dividend| and |divisor| (magnitudes if `signed_i`, raw otherwise).
  - Latch sign bits; `cnt`←0; partial remainder←0.
- `start_i`=1, `annul_i`=0, divisor=0 → BYZERO.
- Otherwise stay in IDLE.

ON, one restoring step per cycle:
- Shift {rem, quo} left 1.
- Trial-subtract divisor from the 33-bit rem.
- If non-negative, keep the difference and set the quotient LSB; otherwise restore.
- `cnt`++.
- Step at `cnt`=31 → END, with the corrected result written to `result_o`.

Signed correction, applied at the ON→END transition:
- Quotient is negated iff sign(dividend) ≠ sign(divisor).
- Remainder is negated iff the dividend is negative.
- All arithmetic is 32-bit two's complement with wrap: −2^31 / −1 gives quotient 0x80000000, remainder 0.

BYZERO:
- `result_o`←64'h0.
- → END next cycle.

END:
- `ready_o`=1; `result_o` held.
- `start_i`=0 → IDLE next edge, `ready_o` drops.
- `start_i` still 1 → stay in END.

Abort:
- `annul_i`=1 in ON, BYZERO or END → IDLE next edge; `ready_o`=0; `result_o` not updated.
- `start_i` dropping in ON or BYZERO → same as abort.

`stall_o`, combinational:
- = (IDLE ∧ `start_i` ∧ ¬`annul_i`) ∨ ON ∨ BYZERO.
- 0 in END.
- Forced 0 while `rst` is low.

## Timing
Reset values (asynchronous on `rst` low):
- State IDLE, `cnt`=0.
- `result_o`=64'h0, `ready_o`=0, `stall_o`=0.

Latency, with `start_i` first high in IDLE during cycle N:
- ON occupies cycles N+1..N+32.
- `ready_o`=1 from cycle N+33.
- `stall_o`=1 in cycles N..N+32, 0 in N+33.

Divide-by-zero latency:
- BYZERO in cycle N+1.
- `ready_o`=1 from cycle N+2.

Back-to-back divides:
- Requester must drop `start_i` for at least one cycle after `ready_o`. END→IDLE costs that one cycle.
- Minimum issue interval is 35 cycles.

Operand stability:
- Operand changes after the sampling edge have no effect.

Reset mid-operation:
- Immediate return to IDLE, all outputs at reset values.
- No partial result is ever presented.

`annul_i` priority:
- Overrides `start_i` in the same cycle: no transition out of IDLE.

## Test plan
- Unsigned: `signed_i`=0, 100 / 7 (0x64 / 0x7), start in cycle N.
  - `ready_o` rises at N+33; `result_o`=64'h00000002_0000000E.
  - `stall_o` high N..N+32.
- Signed sign rules: −7 / 2 (0xFFFFFFF9 / 0x2) → 64'hFFFFFFFF_FFFFFFFD.
  - Also 7 / −2 → 64'h00000001_FFFFFFFD.
- Overflow corner: signed 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000.
  - Unsigned 0xFFFFFFFF / 1 → 64'h00000000_FFFFFFFF.
- Divide by zero: 5 / 0.
  - `ready_o` at N+2, `result_o`=0, `stall_o` high only N..N+1.
- Abort: `annul_i` pulsed at N+10.
  - IDLE at N+11, `stall_o` low, `ready_o` never rises.
  - A fresh 100 / 7 started at N+12 completes normally at N+45.
- Handshake/reset:
  - `start_i` held 3 cycles past `ready_o` → `ready_o` and `result_o` stay stable; drop `start_i` → IDLE next cycle.
  - `rst` low at N+20 → outputs 0 immediately; after release, new divide correct.
